// File: rtl/mod7_decoder.sv
// mod7_decoder
// Receive-side companion to the mod7 up/down counter. It samples the
// counter's 3-bit value bus every clock and rebuilds what the counter is
// doing: step enable and direction, wrap events, a signed net lap count and
// illegal observations (value 7, or any jump other than +/-1 mod 7).
//
// Parameters:
//   LAP_W      width of the signed net lap counter
//   STALL_MAX  consecutive unchanged samples in UP/DOWN before falling back
//              to STILL (1..15)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   value       observed counter value (legal 0..6)
//   clr         synchronous clear of laps and err_sticky
//   now_o       one-cycle pulse on a legal +/-1 step
//   dir_o       direction of the last legal step (1 = up, 0 = down)
//   wrap        one-cycle pulse on a 6->0 up step or a 0->6 down step
//   laps        signed net wrap count, modulo 2^LAP_W
//   err         one-cycle pulse on an illegal observation
//   err_sticky  set by err, cleared by rst or clr
//   state       FSM state: SYNC=0, STILL=1, UP=2, DOWN=3
// All outputs are registered.

module mod7_decoder #(
    parameter int LAP_W     = 8,
    parameter int STALL_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       value,
    input  logic             clr,
    output logic             now_o,
    output logic             dir_o,
    output logic             wrap,
    output logic [LAP_W-1:0] laps,
    output logic             err,
    output logic             err_sticky,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        STILL = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } state_e;

    localparam logic [3:0] STALL_LIM = 4'(STALL_MAX);

    state_e           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [3:0]       stall_q, stall_d;
    logic             now_q, now_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic [LAP_W-1:0] laps_q, laps_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;

    logic [3:0] diff;
    logic [2:0] delta;
    logic       isIllegal;
    logic       isUp;
    logic       isDown;
    logic       isSame;
    logic       isWrap;
    logic [3:0] stallInc;

    // delta = (value - prev) mod 7; adding 7 first keeps the subtraction
    // non-negative, and a single conditional subtract folds it into 0..6.
    always_comb begin
        diff      = {1'b0, value} + 4'd7 - {1'b0, prev_q};
        delta     = (diff >= 4'd7) ? 3'(diff - 4'd7) : diff[2:0];
        isIllegal = (value == 3'd7);
        isUp      = !isIllegal && (delta == 3'd1);
        isDown    = !isIllegal && (delta == 3'd6);
        isSame    = !isIllegal && (delta == 3'd0);
        isWrap    = (isUp && prev_q == 3'd6 && value == 3'd0) ||
                    (isDown && prev_q == 3'd0 && value == 3'd6);
        stallInc  = stall_q + 4'd1;
    end

    // Next-state logic. clr zeroes laps/err_sticky first so that a wrap or
    // error in the same cycle is applied on top of the cleared value.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        stall_d  = stall_q;
        now_d    = 1'b0;
        dir_d    = dir_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        laps_d   = clr ? '0 : laps_q;
        sticky_d = clr ? 1'b0 : sticky_q;

        if (isIllegal) begin
            // prev is kept; resynchronise on the next legal value
            err_d   = 1'b1;
            state_d = SYNC;
            stall_d = 4'd0;
        end else if (state_q == SYNC) begin
            // first legal sample only establishes the reference
            prev_d  = value;
            state_d = STILL;
            stall_d = 4'd0;
        end else if (isUp || isDown) begin
            prev_d  = value;
            now_d   = 1'b1;
            dir_d   = isUp;
            wrap_d  = isWrap;
            state_d = isUp ? UP : DOWN;
            stall_d = 4'd0;
            if (isWrap) begin
                laps_d = isUp ? laps_d + LAP_W'(1) : laps_d - LAP_W'(1);
            end
        end else if (!isSame) begin
            err_d   = 1'b1;
            prev_d  = value;
            state_d = STILL;
            stall_d = 4'd0;
        end else if (state_q != STILL) begin
            // unchanged while moving: fall back to STILL after STALL_MAX
            if (stallInc == STALL_LIM) begin
                state_d = STILL;
                stall_d = 4'd0;
            end else begin
                stall_d = stallInc;
            end
        end

        sticky_d = sticky_d | err_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SYNC;
            prev_q   <= 3'd0;
            stall_q  <= 4'd0;
            now_q    <= 1'b0;
            dir_q    <= 1'b1;
            wrap_q   <= 1'b0;
            laps_q   <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            stall_q  <= stall_d;
            now_q    <= now_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            laps_q   <= laps_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign now_o      = now_q;
    assign dir_o      = dir_q;
    assign wrap       = wrap_q;
    assign laps       = laps_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign state      = state_q;

endmodule
